sha256_msg_schedule: RTL and testbench

//  SHA-256 message-schedule expander. Accepts one 512-bit block as 16 32-bit words
//  (W0..W15), then emits the 64-word schedule W0..W63, one word per accepted output beat.

---
 rtl/sha256_msg_schedule_if.sv | 21 ++
 rtl/sha256_msg_schedule.sv | 95 +++++++++
 tb/tb_sha256_msg_schedule.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_schedule_if.sv
// Stream interface for the SHA-256 message-schedule expander: word input and schedule output.
interface sha256_msg_schedule_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_index;
  logic        out_last;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_word, out_index, out_last
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_word, out_index, out_last
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander: loads a 16-word block, then emits W0..W(NUM_OUT-1)
// through a 16-deep sliding window with a single 4-input adder.
module sha256_small_sigma0 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
endmodule

module sha256_small_sigma1 (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
endmodule

module sha256_msg_schedule #(
  parameter int unsigned NUM_OUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sha256_msg_schedule_if.slave  bus
);
  typedef enum logic {LOAD, EXPAND} state_t;

  localparam logic [5:0] LAST_T = 6'(NUM_OUT - 1);

  state_t      state, state_next;
  logic [31:0] win [16];
  logic [3:0]  lcnt;
  logic [5:0]  t;
  logic [31:0] s0, s1, next_word;
  logic        in_fire, out_fire, last_beat;

  sha256_small_sigma0 u_sigma0 (.x(win[1]),  .y(s0));
  sha256_small_sigma1 u_sigma1 (.x(win[14]), .y(s1));

  // Window holds W[t..t+15]; the sum is W[t+16] for every t, so no special case below 16.
  assign next_word = s1 + win[9] + s0 + win[0];

  assign in_fire   = bus.in_valid  && (state == LOAD);
  assign out_fire  = bus.out_ready && (state == EXPAND);
  assign last_beat = (t == LAST_T);

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_word  = '0;
    bus.out_index = t;
    bus.out_last  = 1'b0;
    if (state == LOAD) begin
      bus.in_ready = 1'b1;
    end else begin
      bus.out_valid = 1'b1;
      bus.out_word  = win[0];
      bus.out_last  = last_beat;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (in_fire && lcnt == 4'd15) state_next = EXPAND;
      EXPAND:  if (out_fire && last_beat)    state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) win[i] <= '0;
      lcnt <= '0;
      t    <= '0;
    end else if (in_fire) begin
      for (int unsigned i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= bus.in_word;
      lcnt    <= (lcnt == 4'd15) ? 4'd0 : lcnt + 4'd1;
      t       <= '0;
    end else if (out_fire) begin
      for (int unsigned i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= next_word;
      if (last_beat) begin
        t    <= '0;
        lcnt <= '0;
      end else begin
        t <= t + 6'd1;
      end
    end
  end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule against a reference SHA-256 schedule recurrence.
module tb_sha256_msg_schedule;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_msg_schedule_if bus ();

  sha256_msg_schedule #(.NUM_OUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];
  logic [5:0]  got_i [64];
  logic        got_l [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model();
    for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = ref_s1(exp_w[i-2]) + exp_w[i-7] + ref_s0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic load_block();
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_word  = blk[i];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic emit(input int pct, output int n);
    n = 0;
    for (int c = 0; c < 2000 && n < 64; c++) begin
      bus.out_ready = ($urandom_range(0, 99) < pct);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got_w[n] = bus.out_word;
        got_i[n] = bus.out_index;
        got_l[n] = bus.out_last;
        n++;
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_word = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", bus.out_last); end
    checks++; if (bus.out_index !== 6'd0) begin errors++; $display("FAIL reset_out_index got %0d exp 0", bus.out_index); end
    checks++; if (bus.out_word !== 32'h0) begin errors++; $display("FAIL reset_out_word got %h exp 0", bus.out_word); end
    rst_n = 1'b1;
  endtask

  task automatic test_abc();
    int n;
    set_abc();
    build_model();
    do_reset();
    load_block();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h61626380)
      begin errors++; $display("FAIL abc_latency got valid=%b word=%h exp valid=1 word=61626380", bus.out_valid, bus.out_word); end
    emit(100, n);
    checks++; if (n != 64) begin errors++; $display("FAIL abc_beats got %0d exp 64", n); end
    checks++; if (got_w[16] !== 32'h61626380) begin errors++; $display("FAIL abc_w16 got %h exp 61626380", got_w[16]); end
    checks++; if (got_w[17] !== 32'h000F0000) begin errors++; $display("FAIL abc_w17 got %h exp 000f0000", got_w[17]); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_i[i] !== 6'(i) || got_l[i] !== (i == 63))
        begin errors++; $display("FAIL abc_beat[%0d] got w=%h idx=%0d last=%b exp w=%h idx=%0d last=%b",
                                 i, got_w[i], got_i[i], got_l[i], exp_w[i], i, (i == 63)); end
    end
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      begin errors++; $display("FAIL abc_return_load got in_ready=%b out_valid=%b exp 1 0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_zero();
    int n;
    for (int i = 0; i < 16; i++) blk[i] = '0;
    do_reset();
    load_block();
    emit(100, n);
    checks++; if (n != 64) begin errors++; $display("FAIL zero_beats got %0d exp 64", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_w[i] !== 32'h0 || got_l[i] !== (i == 63))
        begin errors++; $display("FAIL zero_beat[%0d] got w=%h last=%b exp w=0 last=%b", i, got_w[i], got_l[i], (i == 63)); end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    bit stalled = 0;
    logic [31:0] pw;
    logic [5:0] pi;
    set_abc();
    build_model();
    do_reset();
    load_block();
    bus.in_valid = 1'b1;
    bus.in_word = 32'hDEADBEEF;
    for (int c = 0; c < 1000 && n < 64; c++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (bus.out_word !== pw || bus.out_index !== pi)
          begin errors++; $display("FAIL bp_stable got w=%h idx=%0d exp w=%h idx=%0d", bus.out_word, bus.out_index, pw, pi); end
      end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", bus.in_ready); end
      if (bus.out_valid && bus.out_ready) begin
        got_w[n] = bus.out_word;
        got_i[n] = bus.out_index;
        n++;
        stalled = 0;
      end else begin
        stalled = 1;
        pw = bus.out_word;
        pi = bus.out_index;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (n != 64) begin errors++; $display("FAIL bp_beats got %0d exp 64", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_i[i] !== 6'(i))
        begin errors++; $display("FAIL bp_beat[%0d] got w=%h idx=%0d exp w=%h idx=%0d", i, got_w[i], got_i[i], exp_w[i], i); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] src  [32];
    logic [31:0] outw [128];
    int acc = 0;
    int nout = 0;
    int viol = 0;
    bit pend = 0;
    logic [31:0] pend_w;
    for (int i = 0; i < 32; i++) src[i] = 32'((i + 1) * 32'h9E3779B9) ^ 32'(i);
    do_reset();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 600 && nout < 128; c++) begin
      bus.in_valid = (acc < 32) && ($urandom_range(0, 3) != 0);
      bus.in_word  = (acc < 32) ? src[acc] : 32'hFFFF0000;
      @(negedge clk);
      if (pend) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== pend_w)
          begin errors++; $display("FAIL b2b_first_out got valid=%b w=%h exp valid=1 w=%h", bus.out_valid, bus.out_word, pend_w); end
        pend = 0;
      end
      if (bus.out_valid && bus.in_ready) viol++;
      if (bus.in_valid && bus.in_ready) begin
        acc++;
        if (acc == 16 || acc == 32) begin
          pend = 1;
          pend_w = src[acc-16];
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        outw[nout] = bus.out_word;
        nout++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (acc != 32) begin errors++; $display("FAIL b2b_accepted got %0d exp 32", acc); end
    checks++; if (nout != 128) begin errors++; $display("FAIL b2b_beats got %0d exp 128", nout); end
    checks++; if (viol != 0) begin errors++; $display("FAIL b2b_in_ready_in_expand got %0d exp 0", viol); end
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) blk[i] = src[b*16 + i];
      build_model();
      for (int i = 0; i < 64 && b*64 + i < nout; i++) begin
        checks++;
        if (outw[b*64 + i] !== exp_w[i])
          begin errors++; $display("FAIL b2b_blk%0d_w[%0d] got %h exp %h", b, i, outw[b*64 + i], exp_w[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_expand();
    int n;
    bit hit = 0;
    set_abc();
    build_model();
    do_reset();
    load_block();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_index == 6'd30) begin
        hit = 1;
        rst_n = 1'b0;
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    checks++; if (!hit) begin errors++; $display("FAIL rx_reached_30 got 0 exp 1"); end
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_index !== 6'd0)
      begin errors++; $display("FAIL rx_after_reset got valid=%b ready=%b idx=%0d exp 0 1 0",
                               bus.out_valid, bus.in_ready, bus.out_index); end
    load_block();
    emit(100, n);
    checks++; if (n != 64) begin errors++; $display("FAIL rx_beats got %0d exp 64", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_w[i] !== exp_w[i] || got_i[i] !== 6'(i))
        begin errors++; $display("FAIL rx_beat[%0d] got w=%h idx=%0d exp w=%h idx=%0d", i, got_w[i], got_i[i], exp_w[i], i); end
    end
  endtask

  task automatic test_reset_mid_load();
    int n;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_word = 32'hA5A5_0000 | 32'(i);
      @(posedge clk); #1;
    end
    do_reset();
    for (int i = 0; i < 16; i++) blk[i] = 32'((i + 3) * 32'h01234567);
    build_model();
    load_block();
    emit(100, n);
    checks++; if (n != 64) begin errors++; $display("FAIL rl_beats got %0d exp 64", n); end
    checks++; if (got_w[0] !== blk[0]) begin errors++; $display("FAIL rl_w0 got %h exp %h", got_w[0], blk[0]); end
    checks++; if (got_w[16] !== exp_w[16]) begin errors++; $display("FAIL rl_w16 got %h exp %h", got_w[16], exp_w[16]); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_w[i] !== exp_w[i])
        begin errors++; $display("FAIL rl_beat[%0d] got %h exp %h", i, got_w[i], exp_w[i]); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_abc();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_expand();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
